// File: rtl/rs485_dir_ctrl.sv
// RS-485 driver-enable controller: infers transmit direction from MCU TX activity,
// holds the driver for a tail after the last low bit, blanks RX echo, and drops the bus on stuck-low TX.
module rs485_dir_ctrl #(
  parameter int BIT_CYCLES   = 4,
  parameter int HOLD_BITS    = 2,
  parameter int MAX_LOW_BITS = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tx_in,
  input  logic rx_in,
  output logic tx_out,
  output logic rx_out,
  output logic dir_out,
  output logic fault
);

  localparam int HOLD_CYC    = BIT_CYCLES * HOLD_BITS;
  localparam int MAX_LOW_CYC = BIT_CYCLES * MAX_LOW_BITS;
  localparam int HW          = $clog2(HOLD_CYC + 1);
  localparam int LW          = $clog2(MAX_LOW_CYC + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, FAULT} state_t;

  state_t        state;
  logic          tx_m, tx_s, rx_m, rx_s;
  logic [HW-1:0] hcnt;
  logic [LW-1:0] lcnt;

  // rx_out is overridden to 1 in every branch whose next direction is transmit,
  // so it stays aligned with dir_out on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_m    <= 1'b1;
      tx_s    <= 1'b1;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      tx_out  <= 1'b1;
      rx_out  <= 1'b1;
      state   <= IDLE;
      dir_out <= 1'b0;
      fault   <= 1'b0;
      hcnt    <= '0;
      lcnt    <= '0;
    end else begin
      tx_m   <= tx_in;
      tx_s   <= tx_m;
      rx_m   <= rx_in;
      rx_s   <= rx_m;
      tx_out <= tx_s;
      rx_out <= rx_s;
      if (!en) begin
        state   <= IDLE;
        dir_out <= 1'b0;
        fault   <= 1'b0;
        hcnt    <= '0;
        lcnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!tx_s) begin
              state   <= ACTIVE;
              dir_out <= 1'b1;
              rx_out  <= 1'b1;
              lcnt    <= LW'(1);
            end
          end
          ACTIVE: begin
            rx_out <= 1'b1;
            if (tx_s) begin
              state <= HOLD;
              hcnt  <= HW'(HOLD_CYC - 1);
            end else if (lcnt == LW'(MAX_LOW_CYC)) begin
              state   <= FAULT;
              dir_out <= 1'b0;
              fault   <= 1'b1;
              lcnt    <= '0;
              rx_out  <= rx_s;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          HOLD: begin
            rx_out <= 1'b1;
            // A new start bit takes precedence over the tail expiring.
            if (!tx_s) begin
              state <= ACTIVE;
              lcnt  <= LW'(1);
            end else if (hcnt == '0) begin
              state   <= IDLE;
              dir_out <= 1'b0;
              rx_out  <= rx_s;
            end else begin
              hcnt <= hcnt - 1'b1;
            end
          end
          FAULT: begin
            if (!tx_s) begin
              lcnt <= '0;
            end else if (lcnt == LW'(BIT_CYCLES - 1)) begin
              state <= IDLE;
              fault <= 1'b0;
              lcnt  <= '0;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            dir_out <= 1'b0;
            fault   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs485_dir_ctrl.sv
// Bench for rs485_dir_ctrl: expected dir/fault transitions are queued with their edge number,
// and a negedge monitor pops and checks them as the DUT outputs change.
module tb_rs485_dir_ctrl;

  logic clk = 1'b0;
  logic rst, en, tx_in, rx_in;
  logic tx_out, rx_out, dir_out, fault;

  rs485_dir_ctrl #(.BIT_CYCLES(4), .HOLD_BITS(2), .MAX_LOW_BITS(12)) dut (
    .clk(clk), .rst(rst), .en(en), .tx_in(tx_in), .rx_in(rx_in),
    .tx_out(tx_out), .rx_out(rx_out), .dir_out(dir_out), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic dir;
    logic flt;
  } ev_t;

  ev_t  ev_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   leak = 0;
  bit   mon_on = 1'b0;
  logic [1:0] prev = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {dir_out,fault} must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      if (dir_out && !rx_out) leak = leak + 1;
      if ({dir_out, fault} !== prev) begin
        total = total + 1;
        if (ev_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_event: at edge %0d dir=%b fault=%b, required no change", cyc, dir_out, fault);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.cyc != cyc || e.dir !== dir_out || e.flt !== fault) begin
            bad = bad + 1;
            $display("FAIL event: got edge %0d dir=%b fault=%b, required edge %0d dir=%b fault=%b",
                     cyc, dir_out, fault, e.cyc, e.dir, e.flt);
          end
        end
        prev = {dir_out, fault};
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic d, input logic f);
    ev_t e;
    e.cyc = c;
    e.dir = d;
    e.flt = f;
    ev_q.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %b, required %b (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit toggle_rx);
    logic bv;
    for (int i = 0; i < 10; i++) begin
      bv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int k = 0; k < 4; k++) begin
        tx_in = bv;
        if (toggle_rx) rx_in = ~rx_in;
        step(1);
      end
    end
  endtask

  initial begin
    int p, p2;
    rst = 1'b1; en = 1'b1; tx_in = 1'b0; rx_in = 1'b1;

    // Reset with TX held low.
    step(3);
    check("rst_dir", dir_out, 1'b0);
    check("rst_tx", tx_out, 1'b1);
    check("rst_rx", rx_out, 1'b1);
    check("rst_fault", fault, 1'b0);
    p = cyc;
    rst = 1'b0;
    mon_on = 1'b1;
    expect_ev(p + 3, 1'b1, 1'b0);
    step(2);
    check("rel_tx_lat2", tx_out, 1'b1);
    step(1);
    check("rel_tx_fall", tx_out, 1'b0);
    tx_in = 1'b1;
    expect_ev(p + 3 + 11, 1'b0, 1'b0);
    step(15);

    // Single 0x55 frame with RX toggling throughout.
    p = cyc;
    leak = 0;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 47, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1);
    rx_in = 1'b1;
    step(12);
    total = total + 1;
    if (leak != 0) begin
      bad = bad + 1;
      $display("FAIL rx_blank: got %0d cycles with rx_out low while driving, required 0", leak);
    end

    // RX pass-through while idle.
    rx_in = 1'b0;
    step(2);
    check("rx_lat2", rx_out, 1'b1);
    step(1);
    check("rx_pass", rx_out, 1'b0);
    rx_in = 1'b1;
    step(4);

    // Back-to-back frames, second start 5 cycles after first stop begins.
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    send_frame(8'h33, 1'b0);
    step(1);
    p2 = cyc;
    send_frame(8'h55, 1'b0);
    expect_ev(p2 + 47, 1'b0, 1'b0);
    step(12);

    // Start bit lands on the edge where the hold counter reaches zero.
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 27, 1'b0, 1'b0);
    tx_in = 1'b0;
    step(4);
    tx_in = 1'b1;
    step(7);
    check("boundary_dir", dir_out, 1'b1);
    step(1);
    tx_in = 1'b0;
    step(4);
    tx_in = 1'b1;
    step(14);

    // Single-cycle low is a full start.
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 12, 1'b0, 1'b0);
    tx_in = 1'b0;
    step(1);
    tx_in = 1'b1;
    step(14);

    // Stuck-low TX.
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 51, 1'b0, 1'b1);
    expect_ev(p + 106, 1'b0, 1'b0);
    tx_in = 1'b0;
    step(100);
    tx_in = 1'b1;
    step(3);
    check("fault_held", fault, 1'b1);
    step(3);
    check("fault_clear", fault, 1'b0);
    step(4);
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 15, 1'b0, 1'b0);
    tx_in = 1'b0;
    step(4);
    tx_in = 1'b1;
    step(16);

    // en dropped while hcnt==3 in HOLD.
    p = cyc;
    expect_ev(p + 3, 1'b1, 1'b0);
    expect_ev(p + 12, 1'b0, 1'b0);
    tx_in = 1'b0;
    step(4);
    tx_in = 1'b1;
    step(7);
    en = 1'b0;
    step(1);
    check("en_drop_dir", dir_out, 1'b0);
    tx_in = 1'b0;
    step(3);
    check("en0_tx_follow", tx_out, 1'b0);
    check("en0_dir_off", dir_out, 1'b0);
    tx_in = 1'b1;
    step(6);
    en = 1'b1;
    step(20);
    check("en1_idle", dir_out, 1'b0);

    step(5);
    total = total + 1;
    if (ev_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_events: got %0d expected transitions never seen, required 0", ev_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
